alu_muldiv_unit: RTL

- Parametrised multi-cycle RV32M/RV64M multiply/divide execution unit. It sits beside the single-cycle ALU and serves the opcode class the ALU control decodes as M-extension.
- Decodes fun3 itself and runs an iterative shift-add multiplier or a restoring divider, one bit per cycle.
- A start/busy/valid handshake lets the datapath stall the PC while the unit runs.
- Also adds signed/unsigned mixed handling and RISC-V divide-by-zero and overflow semantics, which the plain ALU control does not provide.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_datapath.sv | 100 ++++++++++
 rtl/alu_muldiv_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and operand signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic is_signed_a(input logic [2:0] fun3);
    return (fun3 == MD_MULH) || (fun3 == MD_MULHSU) ||
           (fun3 == MD_DIV) || (fun3 == MD_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic is_signed_b(input logic [2:0] fun3);
    return (fun3 == MD_MULH) || (fun3 == MD_DIV) || (fun3 == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iteration core: operates on operand magnitudes with a 2*WIDTH+1 accumulator.
// Multiply: upper half accumulates the multiplicand, whole register shifts right.
// Divide: restoring division, upper half is the partial remainder, lower half
// shifts the dividend out and the quotient bits in.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [2:0]       fun3_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic [WIDTH-1:0] res_o
);

  localparam int AW = 2 * WIDTH + 1;

  logic [AW-1:0]      acc_q;
  logic [AW-1:0]      acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [2:0]         op_q;
  logic               neg_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     upper_sum;
  logic [AW-1:0]      shifted;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   div_sel;

  // Operand conditioning: strip signs according to the operation
  always_comb begin
    sign_a = is_signed_a(fun3_i) & rs1_i[WIDTH-1];
    sign_b = is_signed_b(fun3_i) & rs2_i[WIDTH-1];
    mag_a  = sign_a ? -rs1_i : rs1_i;
    mag_b  = sign_b ? -rs2_i : rs2_i;
  end

  // One iteration step of either the shift-add multiplier or restoring divider
  always_comb begin
    acc_d     = acc_q;
    upper_sum = '0;
    shifted   = '0;
    if (op_q[2]) begin
      shifted = {acc_q[AW-2:0], 1'b0};
      if (shifted[AW-1:WIDTH] >= {1'b0, opnd_q}) begin
        acc_d = {shifted[AW-1:WIDTH] - {1'b0, opnd_q}, shifted[WIDTH-1:1], 1'b1};
      end else begin
        acc_d = shifted;
      end
    end else begin
      upper_sum = acc_q[AW-1:WIDTH] + {1'b0, opnd_q};
      acc_d     = acc_q[0] ? {1'b0, upper_sum, acc_q[WIDTH-1:1]}
                           : {1'b0, acc_q[AW-1:1]};
    end
  end

  // Sign fix-up and selection of the architectural result
  always_comb begin
    prod    = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    div_sel = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    if (op_q[2]) begin
      res_o = neg_q ? -div_sel : div_sel;
    end else if (op_q == MD_MUL) begin
      res_o = prod[WIDTH-1:0];
    end else begin
      res_o = prod[2*WIDTH-1:WIDTH];
    end
  end

  // Operand/accumulator registers: load on accepted start, step while calculating
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      opnd_q <= '0;
      op_q   <= MD_MUL;
      neg_q  <= 1'b0;
    end else if (load_i) begin
      op_q <= fun3_i;
      if (fun3_i[2]) begin
        acc_q  <= {{(WIDTH+1){1'b0}}, mag_a};
        opnd_q <= mag_b;
        // remainder follows the dividend, quotient follows the sign product
        neg_q  <= fun3_i[1] ? sign_a : (sign_a ^ sign_b);
      end else begin
        acc_q  <= {{(WIDTH+1){1'b0}}, mag_b};
        opnd_q <= mag_a;
        neg_q  <= sign_a ^ sign_b;
      end
    end else if (step_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit. Handshake: a request is taken
// only in IDLE on an edge with start_i=1 and flush_i=0; busy_o is high while
// the operation runs (CALC, FIX); valid_o pulses for one cycle in DONE with
// result_o, which then holds until the next accepted start. flush_i aborts.
module alu_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       fun3_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output state_t           state_o
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    count_q;
  logic             special_q;
  logic [WIDTH-1:0] spec_res_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] dp_res;
  logic             load;
  logic             step;
  logic             last;
  logic             div0;
  logic             ovf;

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .step_i (step),
    .fun3_i (fun3_i),
    .rs1_i  (rs1_i),
    .rs2_i  (rs2_i),
    .res_o  (dp_res)
  );

  // Special-case detection on the incoming request
  always_comb begin
    div0 = fun3_i[2] && (rs2_i == '0);
    ovf  = ((fun3_i == MD_DIV) || (fun3_i == MD_REM)) &&
           (rs1_i == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_i == '1);
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = (count_q == CW'(WIDTH - 1)) || (FAST_SPECIAL && special_q);
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (flush_i)   state_d = IDLE;
        else if (last) state_d = FIX;
      end
      FIX:     state_d = flush_i ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_o   = (state_q == CALC) || (state_q == FIX);
    valid_o  = (state_q == DONE);
    result_o = result_q;
    state_o  = state_q;
  end

  // State register, iteration counter, special-case latch and result register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      count_q    <= '0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        count_q   <= '0;
        special_q <= div0 || ovf;
        if (div0) spec_res_q <= fun3_i[1] ? rs1_i : '1;
        else      spec_res_q <= fun3_i[1] ? '0 : rs1_i;
      end else if (step) begin
        count_q <= count_q + 1'b1;
      end
      if ((state_q == FIX) && !flush_i) begin
        result_q <= special_q ? spec_res_q : dp_res;
      end
    end
  end

endmodule
